// File: rtl/icache_refill_pkg.sv
// Shared I-cache refill types: address slice widths, FSM encoding and AXI constants.
// Imported by the refill interface, beat counter and refill engine.
package icache_refill_pkg;

    localparam int LINE_WORDS  = 8;
    localparam int INDEX_W     = 7;
    localparam int OFFSET_W    = 3;
    localparam int TAG_W       = 20;
    localparam int TAG_ENTRY_W = TAG_W + 1;

    localparam logic [3:0] AXI_ID_DEF = 4'd0;
    localparam logic [7:0] ARLEN_LINE = 8'(LINE_WORDS - 1);
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] BURST_WRAP = 2'b10;
    localparam logic [2:0] SIZE_4B    = 3'b010;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AR,
        ST_RD,
        ST_TAG,
        ST_DONE
    } state_t;

    function automatic logic [LINE_WORDS-1:0] word_onehot(input logic [OFFSET_W-1:0] off);
        logic [LINE_WORDS-1:0] oh;
        oh      = '0;
        oh[off] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/icache_refill_if.sv
// Refill engine bus bundle: miss handshake, AXI4 AR/R channels, data and tag array write ports.
// master = refill engine side, slave = lookup stage / interconnect / arrays side.
interface icache_refill_if;
    import icache_refill_pkg::*;

    logic                   tag_work;
    logic                   miss_req;
    logic [31:0]            miss_addr;
    logic                   miss_ready;

    logic [3:0]             arid;
    logic [31:0]            araddr;
    logic [7:0]             arlen;
    logic [2:0]             arsize;
    logic [1:0]             arburst;
    logic                   arvalid;
    logic                   arready;

    logic [31:0]            rdata;
    logic [1:0]             rresp;
    logic                   rlast;
    logic                   rvalid;
    logic                   rready;

    logic [LINE_WORDS-1:0]  data_wen;
    logic [INDEX_W-1:0]     data_index;
    logic [31:0]            data_wdata;

    logic                   tag_en;
    logic [3:0]             tag_wen;
    logic [31:0]            tag_addr;
    logic [TAG_ENTRY_W-1:0] tag_wdata;

    logic                   fwd_valid;
    logic [31:0]            fwd_data;
    logic                   refill_done;
    logic                   refill_err;

    modport master (
        input  tag_work, miss_req, miss_addr,
        output miss_ready,
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rdata, rresp, rlast, rvalid,
        output rready,
        output data_wen, data_index, data_wdata,
        output tag_en, tag_wen, tag_addr, tag_wdata,
        output fwd_valid, fwd_data, refill_done, refill_err
    );

    modport slave (
        output tag_work, miss_req, miss_addr,
        input  miss_ready,
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rdata, rresp, rlast, rvalid,
        input  rready,
        input  data_wen, data_index, data_wdata,
        input  tag_en, tag_wen, tag_addr, tag_wdata,
        input  fwd_valid, fwd_data, refill_done, refill_err
    );

endinterface

// File: rtl/icache_refill_beatctr.sv
// Modulo-8 beat counter with parallel load and one-hot bank decode; load wins over inc.
// Value visible the cycle after load/inc; no backpressure of its own.
module icache_refill_beatctr
    import icache_refill_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [OFFSET_W-1:0]   load_val,
    input  logic                  inc,
    output logic [OFFSET_W-1:0]   cnt,
    output logic [LINE_WORDS-1:0] cnt_onehot
);

    logic [OFFSET_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (inc) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt        = cnt_q;
    assign cnt_onehot = word_onehot(cnt_q);

endmodule

// File: rtl/icache_refill.sv
// I-cache miss refill: one 8-word AXI4 burst into the data banks, then {valid,tag}; ICACHE_REFILL_CWF_EN selects critical-word-first WRAP.
// 11 cycles acceptance->refill_done on zero-wait AXI; stalls on arready/rvalid, miss_ready low while busy.
module icache_refill
    import icache_refill_pkg::*;
#(
    parameter logic [3:0] AXI_ID = AXI_ID_DEF
) (
    input  logic           clk,
    input  logic           rst,
    icache_refill_if.master bus
);

    state_t        state_q, state_d;
    logic [31:2]   addr_q, addr_d;
    logic          err_q, err_d;

    logic                  accept;
    logic                  ar_hs;
    logic                  beat;
    logic                  fwd_hit;
    logic [OFFSET_W-1:0]   miss_off;
    logic [OFFSET_W-1:0]   start_off;
    logic [OFFSET_W-1:0]   beat_cnt;
    logic [LINE_WORDS-1:0] beat_onehot;

    assign miss_off = addr_q[4:2];

`ifdef ICACHE_REFILL_CWF_EN
    assign start_off   = miss_off;
    assign bus.araddr  = {addr_q[31:2], 2'b00};
    assign bus.arburst = BURST_WRAP;
`else
    assign start_off   = '0;
    assign bus.araddr  = {addr_q[31:5], 5'b0};
    assign bus.arburst = BURST_INCR;
`endif

    assign bus.miss_ready = (state_q == ST_IDLE) && bus.tag_work && !rst;
    assign accept         = bus.miss_req && bus.miss_ready;
    assign ar_hs          = (state_q == ST_AR) && bus.arready;
    assign beat           = (state_q == ST_RD) && bus.rvalid;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    addr_d  = bus.miss_addr[31:2];
                    state_d = ST_AR;
                end
            end
            ST_AR: begin
                if (bus.arready) begin
                    state_d = ST_RD;
                end
            end
            ST_RD: begin
                // rlast alone closes the burst; the counter only steers bank selection.
                if (bus.rvalid) begin
                    if (bus.rresp != RESP_OKAY) begin
                        err_d = 1'b1;
                    end
                    if (bus.rlast) begin
                        state_d = ST_TAG;
                    end
                end
            end
            ST_TAG: begin
                state_d = ST_DONE;
            end
            ST_DONE: begin
                err_d   = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            err_q   <= err_d;
        end
    end

    icache_refill_beatctr u_beatctr (
        .clk        (clk),
        .rst        (rst),
        .load       (ar_hs),
        .load_val   (start_off),
        .inc        (beat),
        .cnt        (beat_cnt),
        .cnt_onehot (beat_onehot)
    );

    assign bus.arid    = AXI_ID;
    assign bus.arlen   = ARLEN_LINE;
    assign bus.arsize  = SIZE_4B;
    assign bus.arvalid = (state_q == ST_AR);
    assign bus.rready  = (state_q == ST_RD);

    assign bus.data_wen   = beat ? beat_onehot : '0;
    assign bus.data_index = addr_q[11:5];
    assign bus.data_wdata = beat ? bus.rdata : '0;

    assign fwd_hit      = beat && (beat_cnt == miss_off);
    assign bus.fwd_valid = fwd_hit;
    assign bus.fwd_data  = fwd_hit ? bus.rdata : '0;

    // An errored line is committed invalid so the next fetch misses again.
    assign bus.tag_en    = (state_q == ST_TAG);
    assign bus.tag_wen   = bus.tag_en ? 4'hF : 4'h0;
    assign bus.tag_addr  = {addr_q[31:5], 5'b0};
    assign bus.tag_wdata = bus.tag_en ? {~err_q, addr_q[31:12]} : '0;

    assign bus.refill_done = (state_q == ST_DONE);
    assign bus.refill_err  = (state_q == ST_DONE) && err_q;

endmodule

// File: tb/tb_icache_refill.sv
// Bench for icache_refill: directed vector table plus randomized refills against a burst-level AXI/array model.
module tb_icache_refill;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    icache_refill_if bif ();

    icache_refill dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          ar_delay;
        int          gap;        // 0 back-to-back, 1 every other cycle, 2 random
        int          err_beat;   // 0-based beat with SLVERR, -1 none
        int          rst_beat;   // assert rst once this many beats landed, -1 none
        logic [31:0] word_base;  // word i of the line = base+i, 0 = random words
        logic [20:0] exp_tag_wdata;
        logic        exp_err;
        int          exp_lat;    // 0 = not checked
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic any_out();
        return |{bif.miss_ready, bif.araddr, bif.arvalid, bif.rready, bif.data_wen,
                 bif.data_index, bif.data_wdata, bif.tag_en, bif.tag_wen, bif.tag_addr,
                 bif.tag_wdata, bif.fwd_valid, bif.fwd_data, bif.refill_done, bif.refill_err};
    endfunction

    task automatic run_refill(input vec_t v);
        logic [31:0] words [8];
        logic [31:0] exp_ar;
        logic [1:0]  exp_burst;
        logic [2:0]  off;
        logic [2:0]  bank;
        int          exp_fwd_beat;
        int          k, lat, n_wr, n_fwd, fwd_beat, cyc;
        logic        err;
        bit          ar_done;
        bit          give;

        off = v.addr[4:2];
        for (int i = 0; i < 8; i++) begin
            words[i] = (v.word_base != 0) ? v.word_base + 32'(i) : $urandom;
        end
`ifdef ICACHE_REFILL_CWF_EN
        exp_ar       = {v.addr[31:2], 2'b00};
        exp_burst    = 2'b10;
        exp_fwd_beat = 0;
`else
        exp_ar       = {v.addr[31:5], 5'b0};
        exp_burst    = 2'b01;
        exp_fwd_beat = int'(off);
`endif
        lat = 0; n_wr = 0; n_fwd = 0; fwd_beat = -1; err = 1'b0;

        bif.tag_work  = 1'b1;
        bif.miss_req  = 1'b1;
        bif.miss_addr = v.addr;
        bif.arready   = 1'b0;
        bif.rvalid    = 1'b0;
        #2;
        chk("accept_ready", 64'(bif.miss_ready), 64'(1));
        tick(); lat++;

        // Address phase; junk R beats must be ignored, later miss_req ignored.
        ar_done = 1'b0; cyc = 0;
        while (!ar_done && cyc < 64) begin
            bif.miss_addr = ~v.addr;
            bif.arready   = (cyc >= v.ar_delay);
            bif.rvalid    = 1'b1;
            bif.rlast     = 1'b1;
            bif.rresp     = 2'b00;
            bif.rdata     = 32'hDEAD_0000 | 32'(cyc);
            #2;
            chk("ar_valid", 64'(bif.arvalid), 64'(1));
            chk("ar_addr", 64'(bif.araddr), 64'(exp_ar));
            chk("ar_burst", 64'(bif.arburst), 64'(exp_burst));
            chk("ar_len_size_id", 64'({bif.arlen, bif.arsize, bif.arid}), 64'({8'd7, 3'b010, 4'd0}));
            chk("ar_rready", 64'(bif.rready), 64'(0));
            chk("busy_miss_ready", 64'(bif.miss_ready), 64'(0));
            if (bif.data_wen != 0) n_wr++;
            ar_done = bif.arvalid && bif.arready;
            tick(); lat++; cyc++;
        end
        if (!ar_done) chk("ar_timeout", 64'(0), 64'(1));

        bif.arready = 1'b0;
        k = 0; cyc = 0;
        while (k < 8 && cyc < 200) begin
            if (k == v.rst_beat) begin
                bif.rvalid   = 1'b0;
                bif.rlast    = 1'b0;
                bif.miss_req = 1'b0;
                rst          = 1'b1;
                tick();
                #2;
                chk("rst_outs_zero", 64'(any_out()), 64'(0));
                chk("rst_writes", 64'(n_wr), 64'(v.rst_beat));
                rst = 1'b0;
                tick();
                #2;
                chk("rst_idle_ready", 64'(bif.miss_ready), 64'(1));
                chk("rst_idle_arvalid", 64'(bif.arvalid), 64'(0));
                return;
            end
            case (v.gap)
                0:       give = 1'b1;
                1:       give = (cyc % 2 == 0);
                default: give = ($urandom_range(0, 1) == 1);
            endcase
            bank       = exp_ar[4:2] + 3'(k);
            bif.rvalid = give;
            bif.rdata  = give ? words[bank] : 32'hBAD0_0BAD;
            bif.rresp  = (give && k == v.err_beat) ? 2'b10 : 2'b00;
            bif.rlast  = give && (k == 7);
            #2;
            chk("rd_rready", 64'(bif.rready), 64'(1));
            chk("rd_arvalid", 64'(bif.arvalid), 64'(0));
            chk("busy_miss_ready", 64'(bif.miss_ready), 64'(0));
            if (bif.data_wen != 0) n_wr++;
            if (bif.fwd_valid) n_fwd++;
            if (give) begin
                chk("rd_wen", 64'(bif.data_wen), 64'(8'(1) << bank));
                chk("rd_index", 64'(bif.data_index), 64'(v.addr[11:5]));
                chk("rd_wdata", 64'(bif.data_wdata), 64'(words[bank]));
                chk("rd_fwd_valid", 64'(bif.fwd_valid), 64'(bank == off));
                if (bank == off) begin
                    chk("rd_fwd_data", 64'(bif.fwd_data), 64'(words[off]));
                    fwd_beat = k;
                end
                if (k == v.err_beat) err = 1'b1;
                if (bif.rready) k++;
            end else begin
                chk("rd_gap_wen", 64'(bif.data_wen), 64'(0));
                chk("rd_gap_fwd", 64'(bif.fwd_valid), 64'(0));
            end
            tick(); lat++; cyc++;
        end
        if (k < 8) chk("rd_timeout", 64'(k), 64'(8));

        bif.miss_req = 1'b0;
        bif.rvalid   = 1'b1;
        bif.rlast    = 1'b1;
        bif.rresp    = 2'b00;
        bif.rdata    = 32'hFEED_F00D;
        #2;
        chk("tag_en", 64'(bif.tag_en), 64'(1));
        chk("tag_wen", 64'(bif.tag_wen), 64'(4'hF));
        chk("tag_addr", 64'(bif.tag_addr), 64'({v.addr[31:5], 5'b0}));
        chk("tag_wdata", 64'(bif.tag_wdata), 64'(v.exp_tag_wdata));
        chk("tag_rready", 64'(bif.rready), 64'(0));
        chk("tag_done_early", 64'(bif.refill_done), 64'(0));
        if (bif.data_wen != 0) n_wr++;
        tick(); lat++;

        #2;
        chk("done", 64'(bif.refill_done), 64'(1));
        chk("done_err", 64'(bif.refill_err), 64'(v.exp_err));
        chk("model_err", 64'(err), 64'(v.exp_err));
        chk("done_tag_en", 64'(bif.tag_en), 64'(0));
        chk("done_miss_ready", 64'(bif.miss_ready), 64'(0));
        if (bif.data_wen != 0) n_wr++;
        if (v.exp_lat != 0) chk("latency", 64'(lat), 64'(v.exp_lat));
        chk("write_count", 64'(n_wr), 64'(8));
        chk("fwd_count", 64'(n_fwd), 64'(1));
        chk("fwd_beat", 64'(fwd_beat), 64'(exp_fwd_beat));
        tick();

        bif.rvalid = 1'b0;
        bif.rlast  = 1'b0;
        #2;
        chk("idle_done_clear", 64'({bif.refill_done, bif.refill_err}), 64'(0));
        chk("idle_ready", 64'(bif.miss_ready), 64'(1));
    endtask

    vec_t tbl [6];
    vec_t rv;

    initial begin
        n_cmp = 0;
        n_bad = 0;

        tbl[0] = '{32'h1FC0_0024, 0, 0, -1, -1, 32'hA0, 21'h11FC00, 1'b0, 11};
        tbl[1] = '{32'h1FC0_0024, 0, 0,  3, -1, 32'hB0, 21'h01FC00, 1'b1, 11};
        tbl[2] = '{32'h8000_105C, 5, 1, -1, -1, 32'hC0, 21'h180001, 1'b0, 0};
        tbl[3] = '{32'h0000_0FE8, 0, 0, -1,  3, 32'hE0, 21'h000000, 1'b0, 0};
        tbl[4] = '{32'h0000_0FE8, 0, 0, -1, -1, 32'hD0, 21'h100000, 1'b0, 11};
        tbl[5] = '{32'h1234_567C, 0, 0,  7, -1, 32'h50, 21'h012345, 1'b1, 11};

        rst           = 1'b1;
        bif.tag_work  = 1'b0;
        bif.miss_req  = 1'b0;
        bif.miss_addr = 32'h0;
        bif.arready   = 1'b0;
        bif.rdata     = 32'h0;
        bif.rresp     = 2'b00;
        bif.rlast     = 1'b0;
        bif.rvalid    = 1'b0;
        repeat (3) tick();
        #2;
        chk("reset_outs_zero", 64'(any_out()), 64'(0));
        chk("reset_consts", 64'({bif.arid, bif.arlen, bif.arsize}), 64'({4'd0, 8'd7, 3'b010}));
`ifdef ICACHE_REFILL_CWF_EN
        chk("reset_arburst", 64'(bif.arburst), 64'(2'b10));
`else
        chk("reset_arburst", 64'(bif.arburst), 64'(2'b01));
`endif

        // Tag-array clear sweep: a pending miss must wait for tag_work.
        rst           = 1'b0;
        bif.miss_req  = 1'b1;
        bif.miss_addr = tbl[0].addr;
        tick();
        for (int i = 0; i < 128; i++) begin
            #2;
            chk("sweep_miss_ready", 64'(bif.miss_ready), 64'(0));
            chk("sweep_arvalid", 64'(bif.arvalid), 64'(0));
            tick();
        end

        for (int i = 0; i < 6; i++) begin
            run_refill(tbl[i]);
        end

        for (int i = 0; i < 20; i++) begin
            rv.addr          = $urandom;
            rv.ar_delay      = $urandom_range(0, 3);
            rv.gap           = 2;
            rv.err_beat      = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 7)) : -1;
            rv.rst_beat      = -1;
            rv.word_base     = 32'h0;
            rv.exp_err       = (rv.err_beat >= 0);
            rv.exp_tag_wdata = {~rv.exp_err, rv.addr[31:12]};
            rv.exp_lat       = 0;
            run_refill(rv);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1);
    end

endmodule
